add_seq_ctrl: RTL

//  Multi-cycle sequencer performing W = SLICE_W*SLICES-bit addition on one shared SLICE_W-bit ripple-carry slice.

---
 rtl/add_seq_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: multi-cycle W-bit adder that reuses one SLICE_W-bit ripple-carry slice, LSB slice first
//
// Optional feature macro: ADDSEQ_SUB_EN (adds sub_i; subtract computes A + ~B + 1)
//
// Ports:
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   start_valid_i  requester presents operands
//   start_ready_o  block accepts an operation (IDLE only)
//   a_i, b_i       W-bit operands
//   c_in_i         carry into the LSB slice
//   sub_i          subtract request (ADDSEQ_SUB_EN only)
//   busy_o         operation in progress or result pending
//   done_valid_o   sum_o/c_out_o/ovf_o are valid
//   done_ready_i   consumer takes the result
//   sum_o          W-bit result
//   c_out_o        unsigned carry out of the MSB slice
//   ovf_o          two's-complement overflow
module add_seq_ctrl #(
  parameter int SLICE_W = 4,
  parameter int SLICES  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_valid_i,
  output logic                       start_ready_o,
  input  logic [SLICE_W*SLICES-1:0]  a_i,
  input  logic [SLICE_W*SLICES-1:0]  b_i,
  input  logic                       c_in_i,
`ifdef ADDSEQ_SUB_EN
  input  logic                       sub_i,
`endif
  output logic                       busy_o,
  output logic                       done_valid_o,
  input  logic                       done_ready_i,
  output logic [SLICE_W*SLICES-1:0]  sum_o,
  output logic                       c_out_o,
  output logic                       ovf_o
);
  localparam int W  = SLICE_W * SLICES;
  localparam int IW = (SLICES > 1) ? $clog2(SLICES) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic               carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic [SLICE_W-1:0] s_sum;
  logic               s_cout;
  logic               last;
  // The one shared slice; the zero-extended add yields its carry-out in the top bit.
  assign {s_cout, s_sum} = {1'b0, a_q[idx_q*SLICE_W +: SLICE_W]}
                         + {1'b0, b_q[idx_q*SLICE_W +: SLICE_W]}
                         + {{SLICE_W{1'b0}}, carry_q};
  assign last = (idx_q == IW'(SLICES - 1));
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start_valid_i) begin
        a_d     = a_i;
`ifdef ADDSEQ_SUB_EN
        b_d     = sub_i ? ~b_i : b_i;
        carry_d = sub_i ? 1'b1 : c_in_i;
`else
        b_d     = b_i;
        carry_d = c_in_i;
`endif
        idx_d   = '0;
        sum_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        sum_d[idx_q*SLICE_W +: SLICE_W] = s_sum;
        carry_d = s_cout;
        if (last) begin
          // Overflow = carry into MSB (recovered as a^b^sum) xor carry out of MSB.
          c_out_d = s_cout;
          ovf_d   = a_q[W-1] ^ b_q[W-1] ^ s_sum[SLICE_W-1] ^ s_cout;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: if (done_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end
  assign start_ready_o = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign done_valid_o  = (state_q == DONE);
  assign sum_o         = sum_q;
  assign c_out_o       = c_out_q;
  assign ovf_o         = ovf_q;
endmodule
